// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS control FSM (Moore) driving datapath muxes and write enables.
// Ports: clk, rst_n (sync, active-low), op, zero, mem_ready in; mux selects, write enables, illegal out.
// Optional addi support is enabled by defining MC_CTRL_ADDI_EN.
module mc_ctrl_fsm #(
  parameter int OP_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            iord,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_src,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            ir_write,
  output logic            reg_write,
  output logic            mem_write,
  output logic            pc_en,
  output logic            illegal
);

  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_RTYP = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
`ifdef MC_CTRL_ADDI_EN
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
`endif

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
`ifdef MC_CTRL_ADDI_EN
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
`endif
    S_JUMP     = 4'd11
  } state_e;

  state_e state_q, state_d;
  logic   pc_write;
  logic   branch;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    illegal    = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYP:      state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEXEC;
`endif
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        iord = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
`endif
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    pc_en = pc_write | (branch & zero);
    // Reset masks every enable and parks the selects on FETCH values.
    if (!rst_n) begin
      state_d    = S_FETCH;
      iord       = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b01;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      pc_en      = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multicycle MIPS control unit that sequences the shared datapath: one ALU, one unified memory port and the 2:1 / 4:1 selector muxes in front of them. A Moore state machine walks each instruction through fetch, decode, execute, memory and write-back. In each state it drives every mux select and write enable. It stalls on a memory-ready handshake and sits between the instruction register and the datapath.

## Interface
- `OP_W`, default 6: opcode width. It is fixed at 6 for MIPS-I and exists only for lint/elaboration checks.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `op`  in  OP_W  opcode field `IR[31:26]`, valid from DECODE onward.
- `zero`  in  1  ALU zero flag, sampled in BRANCH.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `iord`  out  1  address mux select: 0 = PC, 1 = ALUOut.
- `alu_src_a`  out  1  ALU A mux select: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU B mux select: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `alu_op`  out  2  ALU operation: 00 = add, 01 = sub, 10 = decode funct.
- `pc_src`  out  2  PC mux select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `reg_dst`  out  1  write-register mux select: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  write-data mux select: 0 = ALUOut, 1 = memory data.
- `ir_write`, `reg_write`, `mem_write`, `pc_en`  out  1 each  write enables.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- The state register is 4-bit with binary encoding. Outputs decode purely from the state, with two exceptions: `pc_en` and the handshake gating below.
- Unlisted outputs are 0 in every state.
- FETCH drives `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00.
  - `ir_write` and the PC write are asserted only while `mem_ready`=1.
  - Next state is DECODE if `mem_ready`=1, else FETCH.
- DECODE drives `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000000 (R-type) → EXECUTE.
  - 000100 (beq) → BRANCH.
  - 001000 (addi) → ADDIEXEC.
  - 000010 (j) → JUMP.
  - Any other opcode → FETCH, with `illegal`=1 for that cycle.
- MEMADR drives `alu_src_a`=1, `alu_src_b`=10. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD drives `iord`=1. It holds until `mem_ready`=1, then goes to MEMWB.
- MEMWB drives `reg_dst`=0, `mem_to_reg`=1, `reg_write`=1. Next state is FETCH.
- MEMWRITE drives `iord`=1, `mem_write`=1.
  - `mem_write` stays high for every cycle until `mem_ready`=1.
  - Next state is FETCH.
- EXECUTE drives `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next state is ALUWB.
- ALUWB drives `reg_dst`=1, `mem_to_reg`=0, `reg_write`=1. Next state is FETCH.
- BRANCH drives `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01, branch=1. Next state is FETCH.
- ADDIEXEC drives `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state is ADDIWB.
- ADDIWB drives `reg_dst`=0, `mem_to_reg`=0, `reg_write`=1. Next state is FETCH.
- JUMP drives `pc_src`=10 and the PC write. Next state is FETCH.
- `pc_en` = PC write | (branch & `zero`).
- State encodings 12–15 are unreachable. If one is entered anyway: all outputs are 0 and the next state is FETCH.

## Timing
- Reset is sampled on the rising edge of `clk`. While `rst_n`=0:
  - the next state is FETCH;
  - `ir_write`, `reg_write`, `mem_write`, `pc_en` and `illegal` are forced to 0 combinationally;
  - selects show the FETCH values.
- Deasserting `rst_n` mid-instruction abandons the instruction; no partial write occurs after the reset edge.
- Cycle counts with `mem_ready` tied to 1:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2.
- Each memory wait cycle adds one cycle in FETCH, MEMREAD or MEMWRITE.
- `zero` must be valid in the BRANCH cycle itself. `op` must be stable from DECODE until the instruction returns to FETCH.

## Configuration
- Macro `MC_CTRL_ADDI_EN`.
- Defined: ADDIEXEC and ADDIWB exist and opcode 001000 executes as addi.
- Undefined: both states are removed and 001000 is treated as illegal (DECODE → FETCH, `illegal` pulse).
- All other behaviour is identical in both builds.

## Test plan
- Reset, then sequence `op`=100011 (lw) with `mem_ready`=1:
  - states FETCH, DECODE, MEMADR, MEMREAD, MEMWB;
  - `reg_write`=1 with `mem_to_reg`=1 only in cycle 5;
  - `ir_write`=1 only in cycle 1.
- sw with `mem_ready` low for 2 cycles in MEMWRITE → `mem_write` high for 3 cycles, 6 cycles total, no `reg_write`.
- beq with `zero`=1 → `pc_en`=1 and `pc_src`=01 in cycle 3. With `zero`=0 → `pc_en`=0 in cycle 3.
- R-type → `alu_op`=10 in EXECUTE, then `reg_dst`=1 and `reg_write`=1. j → `pc_src`=10 and `pc_en`=1 in cycle 3.
- `op`=111111 → `illegal` pulses for 1 cycle in DECODE, then FETCH. Repeat `op`=001000 with `MC_CTRL_ADDI_EN` undefined → same illegal result; defined → ADDIWB writes with `reg_dst`=0.
- Assert `rst_n`=0 during MEMWRITE → no write enable high during or after the reset edge, and FETCH in the next cycle.
